// File: rtl/cirno_host_pkg.sv
// Shared types and defaults for the cirno host driver.
// Widths here match instr_mem / data_mem of the cirno slice.
package cirno_host_pkg;

    localparam int INST_W_C      = 9;
    localparam int DATA_W_C      = 8;
    localparam int ADDR_W_C      = 8;
    localparam int CYC_W_C       = 16;
    localparam int TIMEOUT_CYC_C = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BOOT,
        RUN,
        DRAIN,
        FINISH
    } host_state_t;

    typedef enum logic [1:0] {
        RB_IDLE,
        RB_READ,
        RB_CAPT,
        RB_HOLD
    } rb_phase_t;

endpackage

// File: rtl/cirno_host_readback.sv
// Data-memory readback engine: one read per byte, captured
// and held on the res_* stream until the consumer accepts it.
module cirno_host_readback
    import cirno_host_pkg::*;
#(
    parameter int DATA_W = DATA_W_C,
    parameter int ADDR_W = ADDR_W_C
) (
    input  logic              clk,
    input  logic              init,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              dmem_re,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              finished
);

    rb_phase_t         phase;
    rb_phase_t         phase_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] left;
    logic [DATA_W-1:0] data;

    always_ff @(posedge clk) begin
        if (init) begin
            phase <= RB_IDLE;
            addr  <= '0;
            left  <= '0;
            data  <= '0;
        end else begin
            phase <= phase_nx;
            if (phase == RB_IDLE && start) begin
                addr <= base;
                left <= len;
            end
            if (phase == RB_CAPT) begin
                data <= dmem_rdata;
            end
            // address wraps naturally at 2**ADDR_W
            if (phase == RB_HOLD && res_ready) begin
                addr <= addr + ADDR_W'(1);
                left <= left - ADDR_W'(1);
            end
        end
    end

    always_comb begin
        phase_nx  = phase;
        dmem_re   = 1'b0;
        res_valid = 1'b0;
        finished  = 1'b0;
        unique case (phase)
            RB_IDLE: begin
                if (start && len != '0) begin
                    phase_nx = RB_READ;
                end
            end
            RB_READ: begin
                dmem_re  = 1'b1;
                phase_nx = RB_CAPT;
            end
            RB_CAPT: begin
                phase_nx = RB_HOLD;
            end
            RB_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    finished = (left == ADDR_W'(1));
                    phase_nx = finished ? RB_IDLE : RB_READ;
                end
            end
            default: phase_nx = RB_IDLE;
        endcase
    end

    assign dmem_addr = addr;
    assign res_data  = data;

endmodule

// File: rtl/cirno_host.sv
// Host driver for cirno: load imem, boot, time the run, read dmem back.
// Define CIRNO_HOST_CSUM_EN to accumulate a checksum of loaded words.
module cirno_host
    import cirno_host_pkg::*;
#(
    parameter int INST_W      = INST_W_C,
    parameter int DATA_W      = DATA_W_C,
    parameter int ADDR_W      = ADDR_W_C,
    parameter int CYC_W       = CYC_W_C,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_C
) (
    input  logic              clk,
    input  logic              init,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] rd_len,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [INST_W-1:0] prog_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_init,
    input  logic              cpu_done,
    output logic              dmem_re,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              job_done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycles,
    output logic [INST_W-1:0] load_csum
);

    localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT_CYC - 1);

    host_state_t       state;
    host_state_t       state_nx;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] rdlen_q;
    logic [ADDR_W-1:0] idx;
    logic              hs;
    logic              take;
    logic              run_seen;
    logic              run_to;
    logic              rb_start;
    logic              rb_finished;

    assign take = (state == IDLE) && start;
    assign hs   = prog_valid && prog_ready;

    always_ff @(posedge clk) begin
        if (init) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        prog_ready = 1'b0;
        cpu_init   = 1'b0;
        job_done   = 1'b0;
        busy       = (state != IDLE);
        rb_start   = 1'b0;
        // done in the first RUN cycle may be left over from the last job
        run_seen   = (state == RUN) && (cycles != '0) && cpu_done;
        run_to     = (state == RUN) && !run_seen && (cycles == TO_LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (prog_len == '0) ? BOOT : LOAD;
                end
            end
            LOAD: begin
                prog_ready = 1'b1;
                if (prog_valid && idx == len_q - ADDR_W'(1)) begin
                    state_nx = BOOT;
                end
            end
            BOOT: begin
                cpu_init = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                if (run_seen) begin
                    rb_start = (rdlen_q != '0);
                    state_nx = rb_start ? DRAIN : FINISH;
                end else if (run_to) begin
                    state_nx = FINISH;
                end
            end
            DRAIN: begin
                if (rb_finished) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                job_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            len_q   <= '0;
            base_q  <= '0;
            rdlen_q <= '0;
            idx     <= '0;
            cycles  <= '0;
            timeout <= 1'b0;
        end else begin
            if (take) begin
                len_q   <= prog_len;
                base_q  <= rd_base;
                rdlen_q <= rd_len;
                idx     <= '0;
                cycles  <= '0;
                timeout <= 1'b0;
            end
            if (hs) begin
                idx <= idx + ADDR_W'(1);
            end
            if (state == RUN) begin
                if (cycles != '1) begin
                    cycles <= cycles + CYC_W'(1);
                end
                if (run_to) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = hs;
    assign imem_addr  = hs ? idx : '0;
    assign imem_wdata = hs ? prog_data : '0;

`ifdef CIRNO_HOST_CSUM_EN
    logic [INST_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (init) begin
            csum_q <= '0;
        end else if (take) begin
            csum_q <= '0;
        end else if (hs) begin
            csum_q <= csum_q + prog_data;
        end
    end

    assign load_csum = csum_q;
`else
    assign load_csum = '0;
`endif

    cirno_host_readback #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_readback (
        .clk        (clk),
        .init       (init),
        .start      (rb_start),
        .base       (base_q),
        .len        (rdlen_q),
        .dmem_re    (dmem_re),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .finished   (rb_finished)
    );

endmodule
